// File: rtl/button_stimulus_gen.sv
// Emulated pushbutton: turns short/long press requests into a raw,
// optionally bouncing button waveform followed by a release gap.
`timescale 1ns/1ps
module button_stimulus_gen #(
  parameter int unsigned SHORT_MS  = 30,
  parameter int unsigned LONG_MS   = 1600,
  parameter int unsigned GAP_MS    = 500,
  parameter bit          BOUNCE_EN = 1'b1
) (
  input  logic       clk_1khz_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_long_i,
  output logic       req_ready_o,
  input  logic       abort_i,
  output logic       button_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] press_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B_ON,
    S_HOLD,
    S_B_OFF,
    S_GAP
  } state_e;

  localparam logic [11:0] SHORT_LAST = 12'(SHORT_MS - 1);
  localparam logic [11:0] LONG_LAST  = 12'(LONG_MS - 1);
  localparam logic [11:0] GAP_LAST   = 12'(GAP_MS - 1);
  localparam logic [11:0] BNC_LAST   = 12'd4;

  // Bit i is the button level in bounce cycle i.
  localparam logic [7:0] ON_PAT  = 8'b0000_1001;
  localparam logic [7:0] OFF_PAT = 8'b0001_0100;

  state_e      state_q, state_d;
  logic [11:0] ph_q, ph_d;
  logic        long_q, long_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        button_q, button_d;
  logic [11:0] hold_last;
  logic        abort_ok;

  assign hold_last = long_q ? LONG_LAST : SHORT_LAST;

  assign abort_ok = abort_i && (state_q == S_B_ON ||
                                state_q == S_HOLD ||
                                state_q == S_B_OFF);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    long_d  = long_q;
    cnt_d   = cnt_q;
    if (abort_ok) begin
      state_d = S_GAP;
      ph_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            long_d  = req_long_i;
            ph_d    = '0;
            state_d = BOUNCE_EN ? S_B_ON : S_HOLD;
          end
        end
        S_B_ON: begin
          if (ph_q == BNC_LAST) begin
            state_d = S_HOLD;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 12'd1;
          end
        end
        S_HOLD: begin
          if (ph_q == hold_last) begin
            state_d = BOUNCE_EN ? S_B_OFF : S_GAP;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 12'd1;
          end
        end
        S_B_OFF: begin
          if (ph_q == BNC_LAST) begin
            state_d = S_GAP;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 12'd1;
          end
        end
        S_GAP: begin
          if (ph_q == GAP_LAST) begin
            state_d = S_IDLE;
            ph_d    = '0;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            ph_d = ph_q + 12'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          ph_d    = '0;
        end
      endcase
    end
  end

  // Button level is registered from the next phase, so it lines up
  // with the state it belongs to.
  always_comb begin
    button_d = 1'b0;
    unique case (state_d)
      S_B_ON:  button_d = ON_PAT[ph_d[2:0]];
      S_HOLD:  button_d = 1'b1;
      S_B_OFF: button_d = OFF_PAT[ph_d[2:0]];
      default: button_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      long_q   <= 1'b0;
      cnt_q    <= '0;
      button_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      long_q   <= long_d;
      cnt_q    <= cnt_d;
      button_q <= button_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_GAP) && (ph_q == GAP_LAST);
  assign button_o    = button_q;
  assign press_cnt_o = cnt_q;

endmodule

// File: tb/tb_button_stimulus_gen.sv
// Self-checking bench for button_stimulus_gen: a table-driven run on a
// small instance plus directed multi-cycle sequences on full-size ones.
`timescale 1ns/1ps
module tb_button_stimulus_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] v = '0;
  logic [2:0] l = '0;
  logic [2:0] a = '0;
  logic [2:0] rdy, btn, busy, done;
  logic [7:0] cnt [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_stimulus_gen u_def (
    .clk_1khz_i(clk), .rst_i(rst),
    .req_valid_i(v[0]), .req_long_i(l[0]), .req_ready_o(rdy[0]),
    .abort_i(a[0]), .button_o(btn[0]), .busy_o(busy[0]),
    .done_o(done[0]), .press_cnt_o(cnt[0]));

  button_stimulus_gen #(.BOUNCE_EN(1'b0)) u_nb (
    .clk_1khz_i(clk), .rst_i(rst),
    .req_valid_i(v[1]), .req_long_i(l[1]), .req_ready_o(rdy[1]),
    .abort_i(a[1]), .button_o(btn[1]), .busy_o(busy[1]),
    .done_o(done[1]), .press_cnt_o(cnt[1]));

  button_stimulus_gen #(.SHORT_MS(1), .LONG_MS(4), .GAP_MS(1)) u_sm (
    .clk_1khz_i(clk), .rst_i(rst),
    .req_valid_i(v[2]), .req_long_i(l[2]), .req_ready_o(rdy[2]),
    .abort_i(a[2]), .button_o(btn[2]), .busy_o(busy[2]),
    .done_o(done[2]), .press_cnt_o(cnt[2]));

  typedef struct packed {
    logic       v, l, a;
    logic       btn, busy, done, rdy;
    logic [7:0] cnt;
  } row_t;

  row_t tbl [41];

  function automatic row_t mk(int iv, int il, int ia, int ib,
                              int iy, int id, int ir, int ic);
    row_t r;
    r.v = 1'(iv); r.l = 1'(il); r.a = 1'(ia);
    r.btn = 1'(ib); r.busy = 1'(iy); r.done = 1'(id);
    r.rdy = 1'(ir); r.cnt = 8'(ic);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_short(int k);
    int on_p [5] = '{1, 0, 0, 1, 0};
    int of_p [5] = '{0, 0, 1, 0, 1};
    if (k < 5)  return on_p[k];
    if (k < 35) return 1;
    if (k < 40) return of_p[k - 35];
    return 0;
  endfunction

  initial begin
    int dk [3];
    int nd;
    // table for u_sm: inputs v,l,a | btn,busy,done,rdy,cnt
    tbl[0]  = mk(1,0,0, 0,0,0,1,0);
    tbl[1]  = mk(1,1,0, 1,1,0,0,0);
    tbl[2]  = mk(0,0,0, 0,1,0,0,0);
    tbl[3]  = mk(0,0,0, 0,1,0,0,0);
    tbl[4]  = mk(0,0,0, 1,1,0,0,0);
    tbl[5]  = mk(0,0,0, 0,1,0,0,0);
    tbl[6]  = mk(0,0,0, 1,1,0,0,0);
    tbl[7]  = mk(0,0,0, 0,1,0,0,0);
    tbl[8]  = mk(0,0,0, 0,1,0,0,0);
    tbl[9]  = mk(0,0,0, 1,1,0,0,0);
    tbl[10] = mk(0,0,0, 0,1,0,0,0);
    tbl[11] = mk(0,0,0, 1,1,0,0,0);
    tbl[12] = mk(0,0,1, 0,1,1,0,0);
    tbl[13] = mk(1,1,0, 0,0,0,1,1);
    tbl[14] = mk(0,0,0, 1,1,0,0,1);
    tbl[15] = mk(0,0,0, 0,1,0,0,1);
    tbl[16] = mk(0,0,0, 0,1,0,0,1);
    tbl[17] = mk(0,0,0, 1,1,0,0,1);
    tbl[18] = mk(0,0,0, 0,1,0,0,1);
    tbl[19] = mk(0,0,0, 1,1,0,0,1);
    tbl[20] = mk(0,0,0, 1,1,0,0,1);
    tbl[21] = mk(0,0,0, 1,1,0,0,1);
    tbl[22] = mk(0,0,0, 1,1,0,0,1);
    tbl[23] = mk(0,0,0, 0,1,0,0,1);
    tbl[24] = mk(0,0,0, 0,1,0,0,1);
    tbl[25] = mk(0,0,0, 1,1,0,0,1);
    tbl[26] = mk(0,0,0, 0,1,0,0,1);
    tbl[27] = mk(0,0,0, 1,1,0,0,1);
    tbl[28] = mk(0,0,0, 0,1,1,0,1);
    tbl[29] = mk(1,1,0, 0,0,0,1,2);
    tbl[30] = mk(0,0,1, 1,1,0,0,2);
    tbl[31] = mk(0,0,0, 0,1,1,0,2);
    tbl[32] = mk(1,0,0, 0,0,0,1,3);
    tbl[33] = mk(0,0,0, 1,1,0,0,3);
    tbl[34] = mk(0,0,0, 0,1,0,0,3);
    tbl[35] = mk(0,0,0, 0,1,0,0,3);
    tbl[36] = mk(0,0,0, 1,1,0,0,3);
    tbl[37] = mk(0,0,0, 0,1,0,0,3);
    tbl[38] = mk(0,0,1, 1,1,0,0,3);
    tbl[39] = mk(0,0,0, 0,1,1,0,3);
    tbl[40] = mk(0,0,0, 0,0,0,1,4);

    // reset, with requests held to show none is taken
    rst = 1'b1;
    v = 3'b111;
    step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_btn%0d", i), int'(btn[i]), 0);
      chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
      chk($sformatf("rst_done%0d", i), int'(done[i]), 0);
      chk($sformatf("rst_rdy%0d", i), int'(rdy[i]), 1);
      chk($sformatf("rst_cnt%0d", i), int'(cnt[i]), 0);
    end
    v = '0;
    rst = 1'b0;

    for (int r = 0; r < 41; r++) begin
      chk($sformatf("tbl%0d_btn", r), int'(btn[2]), int'(tbl[r].btn));
      chk($sformatf("tbl%0d_busy", r), int'(busy[2]), int'(tbl[r].busy));
      chk($sformatf("tbl%0d_done", r), int'(done[2]), int'(tbl[r].done));
      chk($sformatf("tbl%0d_rdy", r), int'(rdy[2]), int'(tbl[r].rdy));
      chk($sformatf("tbl%0d_cnt", r), int'(cnt[2]), int'(tbl[r].cnt));
      v[2] = tbl[r].v;
      l[2] = tbl[r].l;
      a[2] = tbl[r].a;
      step();
    end
    v[2] = 1'b0; l[2] = 1'b0; a[2] = 1'b0;

    // default short press: full waveform and done timing
    v[0] = 1'b1; l[0] = 1'b0;
    for (int k = 0; k < 540; k++) begin
      step();
      if (k == 0) v[0] = 1'b0;
      chk($sformatf("short_btn_k%0d", k), int'(btn[0]), exp_short(k));
      chk($sformatf("short_done_k%0d", k), int'(done[0]), int'(k == 539));
    end
    step();
    chk("short_cnt", int'(cnt[0]), 1);
    chk("short_rdy", int'(rdy[0]), 1);

    // abort at hold cycle 10 of a long press
    v[0] = 1'b1; l[0] = 1'b1;
    for (int k = 0; k < 516; k++) begin
      step();
      if (k == 0) begin v[0] = 1'b0; l[0] = 1'b0; end
      if (k >= 5 && k <= 15)
        chk($sformatf("abort_hold_k%0d", k), int'(btn[0]), 1);
      if (k >= 16)
        chk($sformatf("abort_btn_k%0d", k), int'(btn[0]), 0);
      chk($sformatf("abort_done_k%0d", k), int'(done[0]), int'(k == 515));
      a[0] = (k == 15);
    end
    step();
    chk("abort_cnt", int'(cnt[0]), 2);
    chk("abort_busy", int'(busy[0]), 0);

    // back-to-back presses with valid held
    rst = 1'b1; step(); rst = 1'b0;
    v[0] = 1'b1; l[0] = 1'b0;
    nd = 0;
    for (int k = 0; k < 1700 && nd < 3; k++) begin
      step();
      if (done[0]) begin
        dk[nd] = k;
        nd++;
        if (nd == 3) v[0] = 1'b0;
      end
    end
    chk("b2b_pulses", nd, 3);
    if (nd == 3) begin
      chk("b2b_first", dk[0], 539);
      chk("b2b_gap1", dk[1] - dk[0], 541);
      chk("b2b_gap2", dk[2] - dk[1], 541);
    end
    step(); step();
    chk("b2b_cnt", int'(cnt[0]), 3);
    chk("b2b_idle", int'(busy[0]), 0);

    // reset in the middle of hold
    v[0] = 1'b1; l[0] = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 0) v[0] = 1'b0;
    end
    chk("mid_hold_btn", int'(btn[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_btn", int'(btn[0]), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_cnt", int'(cnt[0]), 0);
    chk("midrst_rdy", int'(rdy[0]), 1);
    nd = 0;
    for (int k = 0; k < 600; k++) begin
      if (done[0]) nd++;
      step();
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_cnt_after", int'(cnt[0]), 0);

    // 256 presses on the small instance: counter wraps
    v[2] = 1'b1; l[2] = 1'b0;
    nd = 0;
    for (int k = 0; k < 256 * 13 + 50 && nd < 256; k++) begin
      step();
      if (done[2]) begin
        nd++;
        if (nd == 256) begin
          v[2] = 1'b0;
          chk("wrap_cnt255", int'(cnt[2]), 255);
        end
      end
    end
    chk("wrap_pulses", nd, 256);
    step(); step();
    chk("wrap_cnt0", int'(cnt[2]), 0);
    chk("wrap_idle", int'(busy[2]), 0);

    // long press without bounce
    v[1] = 1'b1; l[1] = 1'b1;
    for (int k = 0; k < 2100; k++) begin
      step();
      if (k == 0) begin v[1] = 1'b0; l[1] = 1'b0; end
      chk($sformatf("nb_btn_k%0d", k), int'(btn[1]), int'(k < 1600));
      chk($sformatf("nb_done_k%0d", k), int'(done[1]), int'(k == 2099));
    end
    step();
    chk("nb_cnt", int'(cnt[1]), 1);
    chk("nb_idle", int'(busy[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_stimulus_gen.md
BUTTON_STIMULUS_GEN -- requirements
Module: button_stimulus_gen

Interface
REQ-001 SHALL have parameter SHORT_MS, default 30, meaning hold cycles for a short press.
REQ-002 SHALL have parameter LONG_MS, default 1600, meaning hold cycles for a long press.
REQ-003 SHALL have parameter GAP_MS, default 500, meaning release cycles after each press before the next request is accepted.
REQ-004 SHALL have parameter BOUNCE_EN, default 1, meaning 1 enables bounce emulation and 0 gives clean edges.
REQ-005 SHALL have port clk_1khz_i, input, 1 bit: the single clock, 1 kHz, so 1 cycle = 1 ms.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_valid_i, input, 1 bit: press request valid.
REQ-008 SHALL have port req_long_i, input, 1 bit: 1 = long press, 0 = short; sampled only at acceptance.
REQ-009 SHALL have port req_ready_o, output, 1 bit: the generator can accept a request.
REQ-010 SHALL have port abort_i, input, 1 bit: terminate the current press immediately.
REQ-011 SHALL have port button_o, output, 1 bit: emulated raw pushbutton line, driven into pushbutton_p1_i or pushbutton_p2_i.
REQ-012 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse when a press sequence, including its gap, completes.
REQ-014 SHALL have port press_cnt_o, output, 8 bits: count of completed presses.

Function
REQ-015 SHALL implement the FSM states IDLE, B_ON, HOLD, B_OFF and GAP.
REQ-016 SHALL assert req_ready_o combinationally iff state = IDLE; a request is accepted on a clock edge where req_valid_i and req_ready_o are both 1.
REQ-017 SHALL latch req_long_i at acceptance; changes to it afterwards have no effect.
REQ-018 SHALL, on acceptance, go to B_ON if BOUNCE_EN = 1, otherwise to HOLD; button_o is registered, so its first change appears in the cycle after acceptance.
REQ-019 SHALL, in B_ON, drive button_o to the sequence 1,0,0,1,0 over 5 cycles, then go to HOLD.
REQ-020 SHALL, in HOLD, drive button_o = 1 for exactly SHORT_MS or LONG_MS cycles, then go to B_OFF if BOUNCE_EN = 1, otherwise to GAP.
REQ-021 SHALL, in B_OFF, drive button_o to the sequence 0,0,1,0,1 over 5 cycles, then go to GAP.
REQ-022 SHALL, in GAP, drive button_o = 0 for GAP_MS cycles; on the last GAP cycle it pulses done_o, increments press_cnt_o and returns to IDLE.
REQ-023 SHALL drive button_o = 0 in IDLE.
REQ-024 SHALL use a phase counter of 12 bits; parameters greater than 4095 are illegal and the instantiating code does not use them.
REQ-025 SHALL give a total sequence length of 10+SHORT_MS+GAP_MS or 10+LONG_MS+GAP_MS cycles when BOUNCE_EN = 1, and 10 fewer when BOUNCE_EN = 0.
REQ-026 SHALL, when abort_i = 1 in B_ON, HOLD or B_OFF, set button_o = 0 on the next cycle and enter GAP with a full GAP_MS count; done_o pulses and press_cnt_o increments as for a normal press.
REQ-027 SHALL ignore abort_i in IDLE and GAP.
REQ-028 SHALL give abort_i priority over any same-cycle phase transition.
REQ-029 SHALL wrap press_cnt_o from 255 to 0 without a flag.
REQ-030 SHALL ignore req_valid_i while busy; requests are not queued, and the requester holds req_valid_i until it is accepted.
REQ-031 SHALL, when req_valid_i is held continuously, accept the next request on the first IDLE cycle after done_o, giving back-to-back presses.

Reset
REQ-032 SHALL, when rst_i = 1 at a clock edge, set state = IDLE, button_o = 0, busy_o = 0, done_o = 0, press_cnt_o = 0 and clear the phase counter and latched type.
REQ-033 SHALL give reset priority over all other inputs, including in the middle of a press; button_o = 0 in the cycle after the reset edge.
REQ-034 SHALL hold req_ready_o = 1 during reset, while no request is accepted until rst_i = 0.

Verification
REQ-035 SHALL be verified by: short request (defaults) -> button_o = 1,0,0,1,0, then 30 cycles of 1, then 0,0,1,0,1, then 500 cycles of 0; done_o is high once, 540 cycles after acceptance; press_cnt_o = 1.
REQ-036 SHALL be verified by: long request with BOUNCE_EN = 0 -> button_o high for exactly 1600 cycles, then 500 low; done_o 2100 cycles after acceptance.
REQ-037 SHALL be verified by: abort_i at HOLD cycle 10 of a long press -> button_o = 0 next cycle; done_o 500 cycles later; press_cnt_o increments.
REQ-038 SHALL be verified by: req_valid_i held high for 3 short presses -> 3 done_o pulses spaced 541 cycles apart; press_cnt_o = 3.
REQ-039 SHALL be verified by: rst_i at HOLD cycle 5 -> button_o = 0, busy_o = 0, press_cnt_o = 0 next cycle; no done_o pulse.
REQ-040 SHALL be verified by: 256 completed presses, with SHORT_MS = 1 and GAP_MS = 1 -> press_cnt_o wraps to 0.
REQ-041 SHALL be verified by: integration with scoreboard_top (1 short press, 1 long press) -> the score increments on the short press, and the long press produces the long-press action.
